uart_rx: RTL and testbench



---
 rtl/uart_pkg.sv | 26 ++
 rtl/uart_os_tick_gen.sv | 38 +++
 rtl/uart_rx.sv | 155 +++++++++++++++
 tb/tb_uart_rx.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART blocks: the receiver state encoding, default
// clock/baud/oversampling settings, and the oversample divider calculation
// (also used by baud_generator so both sides agree on the tick period).
// -----------------------------------------------------------------------------
package uart_pkg;

    localparam int CLK_FREQ_DEF = 10_000_000;
    localparam int BAUD_DEF     = 9600;
    localparam int OVS_DEF      = 16;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        BREAK
    } rx_state_t;

    // Clocks per oversample tick, rounded to nearest.
    function automatic int calc_div(input int clk_freq, input int baud, input int ovs);
        return (clk_freq + (baud * ovs) / 2) / (baud * ovs);
    endfunction

endpackage

// File: rtl/uart_os_tick_gen.sv
// -----------------------------------------------------------------------------
// uart_os_tick_gen
// Free-running divider producing a one-cycle oversample tick every DIV clocks.
// Ports:
//   clk    - system clock
//   rst_n  - asynchronous active-low reset (counter restarts at 0)
//   o_tick - high for one clk when the counter reaches DIV-1
// -----------------------------------------------------------------------------
module uart_os_tick_gen #(
    parameter int DIV = 65
) (
    input  logic clk,
    input  logic rst_n,
    output logic o_tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] r_count;
    logic          w_wrap;

    assign w_wrap = (r_count == CW'(DIV - 1));

    // NOTE: sequential state is always written with non-blocking assignments
    // so every flop samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (w_wrap) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tick = w_wrap;

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 serial receiver with 16x (OVS) oversampling. The raw line is
// synchronised through two flops; a falling edge starts a frame, the start bit
// is re-checked at its midpoint to reject glitches, then data and stop bits
// are sampled at their midpoints. Good frames produce a one-cycle rx_valid;
// a low stop bit produces a one-cycle frame_error and the receiver waits for
// the line to return high before looking for another start bit.
// Ports:
//   clk         - system clock
//   rst_n       - asynchronous active-low reset
//   rx_serial   - raw serial line (asynchronous, idles high)
//   rx_data     - last correctly received byte
//   rx_valid    - one-cycle strobe, rx_data updated this cycle
//   rx_busy     - high whenever a frame is being processed
//   frame_error - one-cycle strobe, stop bit sampled low
// -----------------------------------------------------------------------------
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLK_FREQ = CLK_FREQ_DEF,
    parameter int BAUD     = BAUD_DEF,
    parameter int OVS      = OVS_DEF,
    parameter int DIV      = calc_div(CLK_FREQ, BAUD, OVS)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx_serial,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_busy,
    output logic       frame_error
);

    localparam int CW = $clog2(OVS);

    logic            r_sync1;
    logic            r_sync2;
    rx_state_t       r_state;
    rx_state_t       w_state_next;
    logic [CW-1:0]   r_cnt;
    logic [2:0]      r_bit_idx;
    logic [7:0]      r_shift;
    logic [7:0]      r_data;
    logic            r_valid;
    logic            r_ferr;

    logic            w_rx_s;
    logic            w_tick;
    logic            w_mid_start;
    logic            w_mid_bit;
    logic            w_shift;
    logic            w_good;
    logic            w_bad;

    uart_os_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk    (clk),
        .rst_n  (rst_n),
        .o_tick (w_tick)
    );

    assign w_rx_s      = r_sync2;
    // Start bit is checked half a bit in; every later bit one full bit after
    // the previous sample, which lands mid-bit.
    assign w_mid_start = w_tick && (r_cnt == CW'(OVS / 2 - 1));
    assign w_mid_bit   = w_tick && (r_cnt == CW'(OVS - 1));

    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case statement can leave it unassigned (no latches).
    always_comb begin
        w_state_next = r_state;
        w_shift      = 1'b0;
        w_good       = 1'b0;
        w_bad        = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rx_s) w_state_next = START;
            end
            START: begin
                if (w_mid_start) w_state_next = w_rx_s ? IDLE : DATA;
            end
            DATA: begin
                if (w_mid_bit) begin
                    w_shift = 1'b1;
                    if (r_bit_idx == 3'd7) w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_mid_bit) begin
                    if (w_rx_s) begin
                        w_good       = 1'b1;
                        w_state_next = IDLE;
                    end else begin
                        w_bad        = 1'b1;
                        w_state_next = BREAK;
                    end
                end
            end
            BREAK: begin
                // No start detection here: a held-low line is one error only.
                if (w_rx_s) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // NOTE: every flop here, shift register and data register included, is
    // reset so the block comes up in a fully defined idle state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_ferr    <= 1'b0;
        end else begin
            r_sync1 <= rx_serial;
            r_sync2 <= r_sync1;
            r_state <= w_state_next;

            // Cleared on every transition and after each data sample, so the
            // count always measures distance from the last reference point.
            if ((w_state_next != r_state) || w_shift) begin
                r_cnt <= '0;
            end else if (w_tick) begin
                r_cnt <= r_cnt + CW'(1);
            end

            if ((w_state_next == DATA) && (r_state != DATA)) begin
                r_bit_idx <= '0;
            end else if (w_shift) begin
                r_bit_idx <= r_bit_idx + 3'd1;
            end

            // LSB arrives first; after eight shifts it sits in bit 0.
            if (w_shift) r_shift <= {w_rx_s, r_shift[7:1]};

            if (w_good) r_data <= r_shift;
            r_valid <= w_good;
            r_ferr  <= w_bad;
        end
    end

    assign rx_data     = r_data;
    assign rx_valid    = r_valid;
    assign rx_busy     = (r_state != IDLE);
    assign frame_error = r_ferr;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
// Self-checking bench for uart_rx. The clock is scaled down (DIV = 13, one bit
// = 208 clk) so the whole run stays short; every timing in the original plan
// is scaled by the same 208/1040 ratio.
// -----------------------------------------------------------------------------
module tb_uart_rx;

    localparam int CLK_FREQ = 2_000_000;
    localparam int BAUD     = 9600;
    localparam int OVS      = 16;
    // (2_000_000 + 9600*16/2) / (9600*16) = 13.5 truncated -> 13
    localparam int DIV      = 13;
    localparam int BIT      = DIV * OVS;              // 208 clk per bit
    localparam int TOL      = 6;                      // ~2.9% of a bit
    localparam int GLITCH   = 60;                     // 300 clk scaled
    // Good-frame latency: half a start bit plus 8 data bits plus one stop bit
    // of ticks, +-1 tick, with a little slack for synchroniser and strobe.
    localparam int LAT_NOM  = (OVS / 2 + 9 * OVS) * DIV;
    localparam int LAT_MIN  = LAT_NOM - DIV;
    localparam int LAT_MAX  = LAT_NOM + DIV + 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx_serial = 1'b1;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_busy;
    logic       frame_error;

    uart_rx #(
        .CLK_FREQ (CLK_FREQ),
        .BAUD     (BAUD),
        .OVS      (OVS)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_serial   (rx_serial),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_busy     (rx_busy),
        .frame_error (frame_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h want 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic check_range(input string name, input int act, input int lo, input int hi);
        n_cmp++;
        if (act < lo || act > hi) begin
            n_fail++;
            $display("FAIL %s: got %0d want %0d..%0d (t=%0t)", name, act, lo, hi, $time);
        end
    endtask

    // Strobe monitor, sampled on the falling edge.
    typedef struct {
        logic [7:0] data;
        int         t;
    } ev_t;

    ev_t valid_q[$];
    int  ferr_q[$];

    always @(negedge clk) begin
        if (rst_n) begin
            if (rx_valid) valid_q.push_back('{rx_data, cyc});
            if (frame_error) ferr_q.push_back(cyc);
            if (rx_valid || frame_error)
                check("strobe_exclusive", int'(rx_valid & frame_error), 0);
        end
    end

    // All stimulus stays aligned to 1 time unit after a rising edge.
    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Drives one 8N1 frame; a bad stop bit holds the line low for 3 bit times.
    // busy_lows counts data-bit midpoints at which rx_busy was low.
    task automatic send_frame(input logic [7:0] d, input int bclk, input logic stop_ok,
                              output int t0, output int busy_lows);
        busy_lows = 0;
        rx_serial = 1'b0;
        t0 = cyc;
        idle(bclk);
        for (int i = 0; i < 8; i++) begin
            rx_serial = d[i];
            idle(bclk / 2);
            if (!rx_busy) busy_lows++;
            idle(bclk - bclk / 2);
        end
        if (stop_ok) begin
            rx_serial = 1'b1;
            idle(bclk);
        end else begin
            rx_serial = 1'b0;
            idle(3 * bclk);
            rx_serial = 1'b1;
        end
    endtask

    // Compares the strobes seen since the last call against the model.
    task automatic check_frame(input string tag, input int exp_nvalid, input int exp_nferr,
                               input logic [7:0] exp_data, input int t0);
        check({tag, "_nvalid"}, valid_q.size(), exp_nvalid);
        check({tag, "_nferr"}, ferr_q.size(), exp_nferr);
        if (exp_nvalid == 1 && valid_q.size() > 0) begin
            check({tag, "_strobe_data"}, valid_q[0].data, exp_data);
            check_range({tag, "_latency"}, valid_q[0].t - t0, LAT_MIN, LAT_MAX);
        end
        check({tag, "_rx_data"}, rx_data, exp_data);
        check({tag, "_busy_idle"}, rx_busy, 0);
        valid_q.delete();
        ferr_q.delete();
    endtask

    typedef struct {
        logic [7:0] data;
        int         bclk;
        logic       stop_ok;
        int         exp_nvalid;
        int         exp_nferr;
        logic [7:0] exp_data;
    } vec_t;

    vec_t       vecs[5];
    logic [7:0] model_data;   // last good byte, as the receiver should hold it
    int         t0, t1, blows, n;

    initial begin
        vecs[0] = '{8'h55, BIT,       1'b1, 1, 0, 8'h55};
        vecs[1] = '{8'hC6, BIT - TOL, 1'b1, 1, 0, 8'hC6};
        vecs[2] = '{8'hC6, BIT + TOL, 1'b1, 1, 0, 8'hC6};
        vecs[3] = '{8'h81, BIT,       1'b0, 0, 1, 8'hC6};
        vecs[4] = '{8'h3C, BIT,       1'b1, 1, 0, 8'h3C};

        // Reset values.
        idle(4);
        check("rst_rx_data", rx_data, 8'h00);
        check("rst_rx_valid", rx_valid, 0);
        check("rst_rx_busy", rx_busy, 0);
        check("rst_frame_error", frame_error, 0);
        rst_n = 1'b1;
        idle(BIT);
        check("idle_busy", rx_busy, 0);
        model_data = 8'h00;

        // Directed vectors.
        for (int i = 0; i < 5; i++) begin
            send_frame(vecs[i].data, vecs[i].bclk, vecs[i].stop_ok, t0, blows);
            idle(2 * BIT);
            check($sformatf("vec%0d_busy_in_frame", i), blows, 0);
            check_frame($sformatf("vec%0d", i), vecs[i].exp_nvalid, vecs[i].exp_nferr,
                        vecs[i].exp_data, t0);
        end
        model_data = 8'h3C;

        // Randomised frames against the model.
        for (int i = 0; i < 8; i++) begin
            logic [7:0] d;
            int         bc;
            logic       ok;
            d  = 8'($urandom_range(0, 255));
            bc = BIT - TOL + int'($urandom_range(0, 2 * TOL));
            ok = ($urandom_range(0, 4) != 0);
            if (ok) model_data = d;
            send_frame(d, bc, ok, t0, blows);
            idle(2 * BIT);
            check_frame($sformatf("rnd%0d", i), ok ? 1 : 0, ok ? 0 : 1, model_data, t0);
        end

        // Back-to-back frames with no idle gap.
        send_frame(8'hA3, BIT, 1'b1, t0, blows);
        send_frame(8'h0F, BIT, 1'b1, t1, blows);
        idle(2 * BIT);
        check("b2b_nvalid", valid_q.size(), 2);
        check("b2b_nferr", ferr_q.size(), 0);
        if (valid_q.size() == 2) begin
            check("b2b_data0", valid_q[0].data, 8'hA3);
            check("b2b_data1", valid_q[1].data, 8'h0F);
            check_range("b2b_lat0", valid_q[0].t - t0, LAT_MIN, LAT_MAX);
            check_range("b2b_spacing", valid_q[1].t - valid_q[0].t, 10 * BIT - DIV, 10 * BIT + DIV);
        end
        check("b2b_rx_data", rx_data, 8'h0F);
        valid_q.delete();
        ferr_q.delete();
        model_data = 8'h0F;

        // Glitch shorter than half a bit.
        rx_serial = 1'b0;
        t0 = cyc;
        idle(GLITCH / 2);
        check("glitch_busy_high", rx_busy, 1);
        idle(GLITCH - GLITCH / 2);
        rx_serial = 1'b1;
        n = 0;
        while (rx_busy && (cyc - t0) < 2 * GLITCH) begin
            idle(1);
            n++;
        end
        check("glitch_busy_drop", rx_busy, 0);
        idle(2 * BIT);
        check("glitch_nvalid", valid_q.size(), 0);
        check("glitch_nferr", ferr_q.size(), 0);
        check("glitch_rx_data", rx_data, model_data);
        valid_q.delete();
        ferr_q.delete();

        // Reset during bit 4 of 0xFF.
        rx_serial = 1'b0;
        idle(BIT);
        rx_serial = 1'b1;
        idle(4 * BIT + BIT / 2);
        check("mrst_busy_before", rx_busy, 1);
        rst_n = 1'b0;
        idle(3);
        check("mrst_rx_data", rx_data, 8'h00);
        check("mrst_rx_valid", rx_valid, 0);
        check("mrst_rx_busy", rx_busy, 0);
        check("mrst_frame_error", frame_error, 0);
        rst_n = 1'b1;
        model_data = 8'h00;
        idle(BIT / 2 + 4 * BIT);
        idle(2 * BIT);
        check("mrst_nvalid", valid_q.size(), 0);
        check("mrst_nferr", ferr_q.size(), 0);
        valid_q.delete();
        ferr_q.delete();
        send_frame(8'h12, BIT, 1'b1, t0, blows);
        idle(2 * BIT);
        check_frame("after_rst", 1, 0, 8'h12, t0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
